// File: rtl/mul8_seq_pkg.sv
// Shared types and step tables for the nibble-serial 8x8 multiplier sequencer.
package mul8_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned STEPS  = 4;
    localparam int unsigned STEP_W = 2;

    // Left shift applied to each step's 8-bit partial product: aL*bL, aH*bL, aL*bH, aH*bH.
    localparam logic [3:0] STEP_SHIFT [STEPS] = '{4'd0, 4'd4, 4'd4, 4'd8};

    // Bit s set means step s uses the high nibble of that operand.
    localparam logic [STEPS-1:0] STEP_SEL_A_HI = 4'b1010;
    localparam logic [STEPS-1:0] STEP_SEL_B_HI = 4'b1100;

    // Place a step's partial product at its weight within the 16-bit accumulator.
    function automatic logic [15:0] align_pp(input logic [7:0] pp, input logic [STEP_W-1:0] step);
        return {8'h00, pp} << STEP_SHIFT[step];
    endfunction

endpackage

// File: rtl/mul8_seq_if.sv
// Operand/result handshake bundle between a requester and mul8_seq.
interface mul8_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/mul8_seq_multiply.sv
// 4x4 unsigned array multiplier cell: AND-gated rows summed at their bit weights.
module multiply (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    logic [7:0] row [4];

    // Form one shifted AND row per multiplier bit.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            row[i] = {4'h0, a_i & {4{b_i[i]}}} << i;
        end
    end

    // Reduce the rows into the 8-bit product.
    always_comb begin
        p_o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            p_o = p_o + row[i];
        end
    end

endmodule

// File: rtl/mul8_seq.sv
// Sequencer forming an 8x8 unsigned product from four passes through one 4x4 multiplier.
module mul8_seq
    import mul8_seq_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    mul8_seq_if.slave   bus,
    output logic        busy
);

    state_e              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [7:0]          a_q;
    logic [7:0]          b_q;
    logic [15:0]         acc_q;
    logic [15:0]         acc_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [3:0]          nib_a;
    logic [3:0]          nib_b;
    logic [7:0]          pp;

    // Select the operand nibbles for the current step from the latched operands.
    always_comb begin
        nib_a = STEP_SEL_A_HI[step_q] ? a_q[7:4] : a_q[3:0];
        nib_b = STEP_SEL_B_HI[step_q] ? b_q[7:4] : b_q[3:0];
    end

    multiply u_mul (
        .a_i (nib_a),
        .b_i (nib_b),
        .p_o (pp)
    );

    // Next accumulator value: add this step's partial product at its weight.
    always_comb begin
        acc_d = acc_q + align_pp(pp, step_q);
    end

    // Control FSM with registered handshake outputs and the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        acc_q      <= '0;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (ZERO_SKIP && (bus.a == '0 || bus.b == '0)) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 1'b1;
                    if (step_q == STEP_W'(STEPS - 1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = acc_q;
    assign busy          = busy_q;

endmodule
